// File: rtl/sw_pkg.sv
// Shared types and widths for the switch conditioning stage.
package sw_pkg;

    localparam int unsigned SW_STROBE_BIT = 8;
    localparam int unsigned SW_DATA_W     = 8;
    localparam int unsigned SW_W          = SW_DATA_W + 1;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        RISING      = 2'd1,
        HIGH_STABLE = 2'd2,
        FALLING     = 2'd3
    } sw_state_t;

endpackage

// File: rtl/sw_conditioner_if.sv
// Switch bank in, conditioned switch bank and strobe events out.
interface sw_conditioner_if;
    import sw_pkg::*;

    logic [SW_W-1:0] SwIn;
    logic [SW_W-1:0] SwOut;
    logic            RiseEvt;
    logic            FallEvt;
    logic            Busy;

    modport master (output SwIn, input SwOut, RiseEvt, FallEvt, Busy);
    modport slave  (input SwIn, output SwOut, RiseEvt, FallEvt, Busy);

endinterface

// File: rtl/sw_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to 0.
module sw_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    // Next values: shift the raw input through two stages.
    always_comb begin
        s1_d = async_i;
        s2_d = s1_q;
    end

    // Synchroniser flops.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sync_o = s2_q;

endmodule

// File: rtl/sw_conditioner.sv
// Synchronises the switch bank, debounces the strobe bit and latches the
// data byte on each qualified strobe rise.
module sw_conditioner
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             Clock,
    input  logic             nReset,
    sw_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SW_W-1:0]      s2;
    logic                 s2_strobe;
    logic [SW_DATA_W-1:0] s2_data;

    sw_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 strobe_q, strobe_d;
    logic [SW_DATA_W-1:0] data_q, data_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 busy_q, busy_d;

    sw_sync #(.WIDTH(SW_W)) u_sync (
        .Clock   (Clock),
        .nReset  (nReset),
        .async_i (bus.SwIn),
        .sync_o  (s2)
    );

    assign s2_strobe = s2[SW_STROBE_BIT];
    assign s2_data   = s2[SW_DATA_W-1:0];

    // Debounce FSM: a strobe change is accepted only after it has persisted
    // at s2 for DEBOUNCE_CYCLES consecutive edges; data is captured on rises.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = strobe_q;
        data_d   = data_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        case (state_q)
            LOW_STABLE: begin
                if (s2_strobe) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        strobe_d = 1'b1;
                        data_d   = s2_data;
                        rise_d   = 1'b1;
                        state_d  = HIGH_STABLE;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = RISING;
                    end
                end
            end
            RISING: begin
                if (!s2_strobe) begin
                    cnt_d   = '0;
                    state_d = LOW_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    strobe_d = 1'b1;
                    data_d   = s2_data;
                    rise_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = HIGH_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!s2_strobe) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        strobe_d = 1'b0;
                        fall_d   = 1'b1;
                        state_d  = LOW_STABLE;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = FALLING;
                    end
                end
            end
            FALLING: begin
                if (s2_strobe) begin
                    cnt_d   = '0;
                    state_d = HIGH_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    strobe_d = 1'b0;
                    fall_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = LOW_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = LOW_STABLE;
            end
        endcase

        busy_d = (state_d == RISING) || (state_d == FALLING);
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= LOW_STABLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            data_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.SwOut   = {strobe_q, data_q};
    assign bus.RiseEvt = rise_q;
    assign bus.FallEvt = fall_q;
    assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench for sw_conditioner: a default build and a DEBOUNCE_CYCLES=1
// build share the same stimulus; a run-length reference model predicts both.
module tb_sw_conditioner;
    import sw_pkg::*;

    localparam int D_A = 16;
    localparam int D_B = 1;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;

    always #5 Clock = ~Clock;

    sw_conditioner_if bus_a ();
    sw_conditioner_if bus_b ();

    sw_conditioner #(.DEBOUNCE_CYCLES(D_A)) dut_a (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus_a.slave)
    );

    sw_conditioner #(.DEBOUNCE_CYCLES(D_B)) dut_b (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus_b.slave)
    );

    // Reference state: two-deep input delay, accepted strobe level, held data
    // byte, and length of the current run of samples disagreeing with it.
    typedef struct {
        logic [8:0] s1;
        logic [8:0] s2;
        logic       o;
        logic [7:0] data;
        int         run;
    } mdl_t;

    typedef struct packed {
        logic [8:0] swout;
        logic       rise;
        logic       fall;
        logic       busy;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } rec_t;

    rec_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mdl_step(input mdl_t m, input int d, input logic [8:0] x,
                                      input logic rst, output exp_t e);
        mdl_t       n;
        logic [8:0] v;
        n      = m;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (rst) begin
            n.s1   = '0;
            n.s2   = '0;
            n.o    = 1'b0;
            n.data = '0;
            n.run  = 0;
        end else begin
            v = m.s2;
            if (v[8] != m.o) begin
                n.run = m.run + 1;
                if (n.run >= d) begin
                    n.o   = v[8];
                    n.run = 0;
                    if (n.o) begin
                        n.data = v[7:0];
                        e.rise = 1'b1;
                    end else begin
                        e.fall = 1'b1;
                    end
                end
            end else begin
                n.run = 0;
            end
            n.s2 = m.s1;
            n.s1 = x;
        end
        e.swout = {n.o, n.data};
        e.busy  = (n.run != 0);
        return n;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model over the edge, queue the prediction.
    task automatic step(input logic [8:0] x, input logic rst_n_i);
        rec_t r;
        bus_a.SwIn = x;
        bus_b.SwIn = x;
        nReset     = rst_n_i;
        @(posedge Clock);
        ma = mdl_step(ma, D_A, x, !rst_n_i, r.a);
        mb = mdl_step(mb, D_B, x, !rst_n_i, r.b);
        sb_q.push_back(r);
        #1;
    endtask

    task automatic hold(input logic [8:0] x, input int n);
        for (int i = 0; i < n; i++) step(x, 1'b1);
    endtask

    // Monitor: every cycle the DUTs present outputs; compare with the oldest prediction.
    always @(negedge Clock) begin
        rec_t r;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check("a_swout", bus_a.SwOut,        r.a.swout);
            check("a_rise",  9'(bus_a.RiseEvt),  9'(r.a.rise));
            check("a_fall",  9'(bus_a.FallEvt),  9'(r.a.fall));
            check("a_busy",  9'(bus_a.Busy),     9'(r.a.busy));
            check("b_swout", bus_b.SwOut,        r.b.swout);
            check("b_rise",  9'(bus_b.RiseEvt),  9'(r.b.rise));
            check("b_fall",  9'(bus_b.FallEvt),  9'(r.b.fall));
            check("b_busy",  9'(bus_b.Busy),     9'(r.b.busy));
        end
    end

    initial begin
        exp_t       e0;
        logic [7:0] dat;
        logic       stb;
        int         len;

        ma = mdl_step(ma, D_A, 9'h000, 1'b1, e0);
        mb = mdl_step(mb, D_B, 9'h000, 1'b1, e0);

        // Reset held with all switches high, then released.
        for (int i = 0; i < 3; i++) step(9'h1FF, 1'b0);
        hold(9'h1FF, 25);

        // Clean handshake; data changes while high must not leak through.
        hold(9'h0A5, 22);
        hold(9'h1A5, 22);
        hold(9'h13C, 10);
        hold(9'h03C, 22);

        // Glitches: 15-cycle pulse rejected, 16-cycle pulse accepted.
        hold(9'h155, 15);
        hold(9'h055, 22);
        hold(9'h166, 16);
        hold(9'h066, 22);

        // Bounce, then settle high.
        for (int i = 0; i < 40; i++) step({((i / 3) % 2 == 0), 8'h5A}, 1'b1);
        hold(9'h15A, 25);

        // Reset ten cycles into a rise qualification.
        hold(9'h000, 22);
        hold(9'h1C3, 12);
        #5;
        nReset = 1'b0;
        #1;
        check("rst_async_swout", bus_a.SwOut,       9'h000);
        check("rst_async_rise",  9'(bus_a.RiseEvt), 9'h000);
        check("rst_async_busy",  9'(bus_a.Busy),    9'h000);
        for (int i = 0; i < 3; i++) step(9'h1C3, 1'b0);
        hold(9'h1C3, 25);

        // Single-cycle strobe pulses (passed only by the DEBOUNCE_CYCLES=1 build).
        hold(9'h000, 22);
        hold(9'h111, 1);
        hold(9'h011, 6);
        hold(9'h122, 1);
        hold(9'h022, 6);

        // Random strobe runs with data churning underneath.
        for (int s = 0; s < 40; s++) begin
            len = int'($urandom_range(1, 24));
            stb = 1'($urandom_range(0, 1));
            dat = 8'($urandom);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) dat = 8'($urandom);
                step({stb, dat}, 1'b1);
            end
        end
        hold(9'h000, 22);

        repeat (2) @(negedge Clock);
        #1;
        check("sb_drain", 9'(sb_q.size()), 9'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
